lsu_pipe: RTL and testbench

// - Parametrised, handshaked load/store unit for the multi-cycle RV32I core.
// - Accepts one request at a time over valid/ready and decodes the address into

---
 rtl/lsu_pkg.sv | 35 +++
 rtl/lsu_align.sv | 52 +++++
 rtl/lsu_pipe.sv | 176 +++++++++++++++++
 tb/tb_lsu_pipe.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and helpers for the load/store unit
package lsu_pkg;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } lsu_op_e;

  typedef enum logic [1:0] {
    ERR_OK    = 2'b00,
    ERR_ALIGN = 2'b01,
    ERR_MAP   = 2'b10,
    ERR_TMO   = 2'b11
  } lsu_err_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUS  = 2'b01,
    RESP = 2'b10
  } lsu_state_e;

  localparam int SEL_DMEM = 0;
  localparam int SEL_OPER = 1;
  localparam int SEL_IPER = 2;

  // Half-open region test [base, base+size)
  function automatic logic in_region(input logic [31:0] a, input logic [31:0] base,
                                     input logic [31:0] size);
    return (a >= base) && (a < base + size);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - load lane extraction/extension and store lane replication
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  ld_op_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] ld_data_o,
  input  logic [1:0]  st_size_i,
  input  logic [1:0]  st_off_i,
  input  logic [31:0] st_data_i,
  output logic [3:0]  st_be_o,
  output logic [31:0] st_wdata_o
);

  logic [31:0] shifted;

  assign shifted = rdata_i >> {ld_off_i, 3'b000};

  // Move the addressed lane to bit 0 and extend it according to the load op
  always_comb begin
    ld_data_o = rdata_i;
    case (ld_op_i)
      LB:      ld_data_o = {{24{shifted[7]}}, shifted[7:0]};
      LH:      ld_data_o = {{16{shifted[15]}}, shifted[15:0]};
      LBU:     ld_data_o = {24'h0, shifted[7:0]};
      LHU:     ld_data_o = {16'h0, shifted[15:0]};
      default: ld_data_o = rdata_i;
    endcase
  end

  // Replicate store data across lanes so the byte enables alone pick the target
  always_comb begin
    st_be_o    = 4'hF;
    st_wdata_o = st_data_i;
    case (st_size_i)
      2'b00: begin
        st_be_o    = 4'b0001 << st_off_i;
        st_wdata_o = {4{st_data_i[7:0]}};
      end
      2'b01: begin
        st_be_o    = 4'b0011 << st_off_i;
        st_wdata_o = {2{st_data_i[15:0]}};
      end
      default: begin
        st_be_o    = 4'hF;
        st_wdata_o = st_data_i;
      end
    endcase
  end

endmodule

// File: rtl/lsu_pipe.sv
// rtl/lsu_pipe.sv - handshaked load/store unit with region decode and bus timeout
module lsu_pipe
  import lsu_pkg::*;
#(
  parameter int          ADDR_W    = 16,
  parameter logic [31:0] DMEM_BASE = 32'h2000,
  parameter logic [31:0] DMEM_SIZE = 32'h2000,
  parameter logic [31:0] OPER_BASE = 32'h7000,
  parameter logic [31:0] OPER_SIZE = 32'h0040,
  parameter logic [31:0] IPER_BASE = 32'h7800,
  parameter logic [31:0] IPER_SIZE = 32'h0020,
  parameter int          TIMEOUT   = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [2:0]        i_lsu_op,
  input  logic              i_lsu_wren,
  input  logic [31:0]       i_lsu_addr,
  input  logic [31:0]       i_st_data,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [31:0]       o_ld_data,
  output logic [1:0]        o_rsp_err,
  output logic              o_bus_req,
  output logic              o_bus_we,
  output logic [ADDR_W-1:0] o_bus_addr,
  output logic [31:0]       o_bus_wdata,
  output logic [3:0]        o_bus_be,
  output logic [2:0]        o_bus_sel,
  input  logic              i_bus_ack,
  input  logic [31:0]       i_bus_rdata
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  lsu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        op_q, op_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic [2:0]        sel_q, sel_d;
  logic [31:0]       ld_q, ld_d;
  lsu_err_e          err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_a32;
  logic [2:0]        req_sel;
  logic              op_ok, align_bad;
  lsu_err_e          req_err;
  logic [31:0]       ld_ext, st_wdata;
  logic [3:0]        st_be;
  logic              addr_hi_unused;

  assign req_addr       = i_lsu_addr[ADDR_W-1:0];
  assign req_a32        = 32'(req_addr);
  assign addr_hi_unused = ^i_lsu_addr[31:ADDR_W];

  lsu_align u_align (
    .ld_op_i    (op_q),
    .ld_off_i   (addr_q[1:0]),
    .rdata_i    (i_bus_rdata),
    .ld_data_o  (ld_ext),
    .st_size_i  (i_lsu_op[1:0]),
    .st_off_i   (i_lsu_addr[1:0]),
    .st_data_i  (i_st_data),
    .st_be_o    (st_be),
    .st_wdata_o (st_wdata)
  );

  // Decode the incoming request: region select and prioritised error code
  always_comb begin
    req_sel           = '0;
    req_sel[SEL_DMEM] = in_region(req_a32, DMEM_BASE, DMEM_SIZE);
    req_sel[SEL_OPER] = in_region(req_a32, OPER_BASE, OPER_SIZE);
    req_sel[SEL_IPER] = in_region(req_a32, IPER_BASE, IPER_SIZE);
    op_ok = i_lsu_wren ? (i_lsu_op == LB || i_lsu_op == LH || i_lsu_op == LW)
                       : (i_lsu_op == LB || i_lsu_op == LH || i_lsu_op == LW ||
                          i_lsu_op == LBU || i_lsu_op == LHU);
    align_bad = ((i_lsu_op[1:0] == 2'b01) && req_addr[0]) ||
                ((i_lsu_op == LW) && (req_addr[1:0] != 2'b00));
    if (!op_ok || align_bad)                 req_err = ERR_ALIGN;
    else if (req_sel == 3'b000)              req_err = ERR_MAP;
    else if (i_lsu_wren && req_sel[SEL_IPER]) req_err = ERR_MAP;
    else                                     req_err = ERR_OK;
  end

  // Next-state logic: accept, bus wait with timeout, hold response until taken
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    op_d    = op_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    sel_d   = sel_q;
    ld_d    = ld_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (i_req_valid) begin
          addr_d  = req_addr;
          op_d    = i_lsu_op;
          we_d    = i_lsu_wren;
          wdata_d = st_wdata;
          be_d    = i_lsu_wren ? st_be : 4'hF;
          sel_d   = req_sel;
          ld_d    = '0;
          cnt_d   = '0;
          err_d   = req_err;
          state_d = (req_err == ERR_OK) ? BUS : RESP;
        end
      end
      BUS: begin
        if (i_bus_ack) begin
          ld_d    = we_q ? 32'h0 : ld_ext;
          err_d   = ERR_OK;
          state_d = RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          ld_d    = '0;
          err_d   = ERR_TMO;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        if (i_rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and request registers; reset abandons any transaction in flight
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      op_q    <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      be_q    <= '0;
      sel_q   <= '0;
      ld_q    <= '0;
      err_q   <= ERR_OK;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      op_q    <= op_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      sel_q   <= sel_d;
      ld_q    <= ld_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_req_ready = (state_q == IDLE);
  assign o_rsp_valid = (state_q == RESP);
  assign o_ld_data   = o_rsp_valid ? ld_q : 32'h0;
  assign o_rsp_err   = o_rsp_valid ? err_q : 2'b00;
  assign o_bus_req   = (state_q == BUS);
  assign o_bus_we    = o_bus_req & we_q;
  assign o_bus_addr  = o_bus_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign o_bus_wdata = o_bus_req ? wdata_q : 32'h0;
  assign o_bus_be    = o_bus_req ? be_q : 4'h0;
  assign o_bus_sel   = o_bus_req ? sel_q : 3'b000;

endmodule

// File: tb/tb_lsu_pipe.sv
// tb/tb_lsu_pipe.sv - directed self-checking bench for lsu_pipe
module tb_lsu_pipe;

  logic        i_clk, i_rst;
  logic        i_req_valid, o_req_ready;
  logic [2:0]  i_lsu_op;
  logic        i_lsu_wren;
  logic [31:0] i_lsu_addr, i_st_data;
  logic        o_rsp_valid, i_rsp_ready;
  logic [31:0] o_ld_data;
  logic [1:0]  o_rsp_err;
  logic        o_bus_req, o_bus_we;
  logic [15:0] o_bus_addr;
  logic [31:0] o_bus_wdata;
  logic [3:0]  o_bus_be;
  logic [2:0]  o_bus_sel;
  logic        i_bus_ack;
  logic [31:0] i_bus_rdata;

  int tests_run = 0;
  int tests_failed = 0;

  lsu_pipe dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_lsu_op(i_lsu_op), .i_lsu_wren(i_lsu_wren),
    .i_lsu_addr(i_lsu_addr), .i_st_data(i_st_data),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_ld_data(o_ld_data), .o_rsp_err(o_rsp_err),
    .o_bus_req(o_bus_req), .o_bus_we(o_bus_we),
    .o_bus_addr(o_bus_addr), .o_bus_wdata(o_bus_wdata),
    .o_bus_be(o_bus_be), .o_bus_sel(o_bus_sel),
    .i_bus_ack(i_bus_ack), .i_bus_rdata(i_bus_rdata)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Present a request for one edge; returns at the negedge after acceptance
  task automatic issue(input logic [2:0] op, input logic we, input logic [31:0] addr,
                       input logic [31:0] d);
    i_req_valid = 1'b1; i_lsu_op = op; i_lsu_wren = we; i_lsu_addr = addr; i_st_data = d;
    @(posedge i_clk); @(negedge i_clk);
    i_req_valid = 1'b0;
  endtask

  task automatic ack_now(input logic [31:0] rd);
    i_bus_rdata = rd; i_bus_ack = 1'b1;
    @(posedge i_clk); @(negedge i_clk);
    i_bus_ack = 1'b0;
  endtask

  task automatic handshake();
    i_rsp_ready = 1'b1;
    @(posedge i_clk); @(negedge i_clk);
    i_rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b0; i_req_valid = 0; i_lsu_op = 0; i_lsu_wren = 0; i_lsu_addr = 0;
    i_st_data = 0; i_rsp_ready = 0; i_bus_ack = 0; i_bus_rdata = 0;
    repeat (3) @(negedge i_clk);
    tests_run++;
    if ({o_req_ready, o_rsp_valid, o_bus_req, o_bus_we} !== 4'b1000) begin
      tests_failed++;
      $display("FAIL reset_flags got=%b want=1000", {o_req_ready, o_rsp_valid, o_bus_req, o_bus_we});
    end
    tests_run++;
    if ({o_ld_data, o_rsp_err, o_bus_addr, o_bus_wdata, o_bus_be, o_bus_sel} !== 89'h0) begin
      tests_failed++;
      $display("FAIL reset_data got=%h want=0", {o_ld_data, o_rsp_err, o_bus_addr, o_bus_wdata, o_bus_be, o_bus_sel});
    end
    i_rst = 1'b1;
    @(negedge i_clk);
  endtask

  task automatic test_store();
    logic [2:0]  op [4];
    logic [31:0] ad [4], dt [4], ew [4];
    logic [3:0]  eb [4];
    logic [2:0]  es [4];
    op = '{3'b000, 3'b001, 3'b010, 3'b000};
    ad = '{32'h2003, 32'h2002, 32'h2004, 32'h7001};
    dt = '{32'h000000A5, 32'h1234BEEF, 32'hDEADBEEF, 32'h0000005A};
    ew = '{32'hA5A5A5A5, 32'hBEEFBEEF, 32'hDEADBEEF, 32'h5A5A5A5A};
    eb = '{4'b1000, 4'b1100, 4'b1111, 4'b0010};
    es = '{3'b001, 3'b001, 3'b001, 3'b010};
    for (int i = 0; i < 4; i++) begin
      issue(op[i], 1'b1, ad[i], dt[i]);
      tests_run++;
      if ({o_bus_req, o_bus_we, o_bus_be, o_bus_sel, o_bus_wdata, o_bus_addr} !==
          {2'b11, eb[i], es[i], ew[i], ad[i][15:2], 2'b00}) begin
        tests_failed++;
        $display("FAIL store_bus[%0d] got be=%b sel=%b wd=%h a=%h req=%b we=%b want be=%b sel=%b wd=%h",
                 i, o_bus_be, o_bus_sel, o_bus_wdata, o_bus_addr, o_bus_req, o_bus_we, eb[i], es[i], ew[i]);
      end
      ack_now(32'h11223344);
      tests_run++;
      if ({o_rsp_valid, o_rsp_err, o_ld_data, o_bus_req} !== {1'b1, 2'b00, 32'h0, 1'b0}) begin
        tests_failed++;
        $display("FAIL store_rsp[%0d] got v=%b err=%b ld=%h req=%b want v=1 err=00 ld=0 req=0",
                 i, o_rsp_valid, o_rsp_err, o_ld_data, o_bus_req);
      end
      handshake();
    end
  endtask

  task automatic test_loads();
    logic [2:0]  op [6];
    logic [31:0] ad [6], ex [6];
    op = '{3'b001, 3'b101, 3'b000, 3'b010, 3'b100, 3'b000};
    ad = '{32'h2002, 32'h2002, 32'h2001, 32'h2000, 32'h2003, 32'h2003};
    ex = '{32'hFFFF80F0, 32'h000080F0, 32'h00000012, 32'h80F01234, 32'h00000080, 32'hFFFFFF80};
    for (int i = 0; i < 6; i++) begin
      issue(op[i], 1'b0, ad[i], 32'hFFFFFFFF);
      tests_run++;
      if ({o_bus_req, o_bus_we, o_bus_be, o_bus_addr} !== {2'b10, 4'hF, 16'h2000}) begin
        tests_failed++;
        $display("FAIL load_bus[%0d] got req=%b we=%b be=%b a=%h want req=1 we=0 be=1111 a=2000",
                 i, o_bus_req, o_bus_we, o_bus_be, o_bus_addr);
      end
      ack_now(32'h80F01234);
      tests_run++;
      if ({o_rsp_valid, o_rsp_err, o_ld_data} !== {1'b1, 2'b00, ex[i]}) begin
        tests_failed++;
        $display("FAIL load_data[%0d] got v=%b err=%b ld=%h want v=1 err=00 ld=%h",
                 i, o_rsp_valid, o_rsp_err, o_ld_data, ex[i]);
      end
      handshake();
    end
  endtask

  task automatic test_decode();
    logic [2:0]  op [13];
    logic        we [13];
    logic [31:0] ad [13];
    logic [1:0]  ee [13];
    logic [2:0]  es [13];
    op = '{3'b010, 3'b010, 3'b010, 3'b011, 3'b100, 3'b001, 3'b010, 3'b010, 3'b000,
           3'b010, 3'b010, 3'b000, 3'b010};
    we = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    ad = '{32'h2002, 32'h7804, 32'h5000, 32'h2000, 32'h2000, 32'h2001, 32'h4000, 32'h7040,
           32'h7820, 32'h3FFC, 32'h703C, 32'h781F, 32'hFFFF2000};
    ee = '{2'b01, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10,
           2'b00, 2'b00, 2'b00, 2'b00};
    es = '{3'b0, 3'b0, 3'b0, 3'b0, 3'b0, 3'b0, 3'b0, 3'b0, 3'b0,
           3'b001, 3'b010, 3'b100, 3'b001};
    for (int i = 0; i < 13; i++) begin
      issue(op[i], we[i], ad[i], 32'h0);
      if (ee[i] != 2'b00) begin
        tests_run++;
        if ({o_rsp_valid, o_rsp_err, o_bus_req, o_ld_data} !== {1'b1, ee[i], 1'b0, 32'h0}) begin
          tests_failed++;
          $display("FAIL decode_err[%0d] got v=%b err=%b req=%b ld=%h want v=1 err=%b req=0 ld=0",
                   i, o_rsp_valid, o_rsp_err, o_bus_req, o_ld_data, ee[i]);
        end
      end else begin
        tests_run++;
        if ({o_bus_req, o_bus_sel} !== {1'b1, es[i]}) begin
          tests_failed++;
          $display("FAIL decode_sel[%0d] got req=%b sel=%b want req=1 sel=%b",
                   i, o_bus_req, o_bus_sel, es[i]);
        end
        ack_now(32'h0);
        tests_run++;
        if ({o_rsp_valid, o_rsp_err} !== 3'b100) begin
          tests_failed++;
          $display("FAIL decode_ok[%0d] got v=%b err=%b want v=1 err=00", i, o_rsp_valid, o_rsp_err);
        end
      end
      handshake();
    end
  endtask

  task automatic test_timeout();
    int cycles;
    issue(3'b010, 1'b0, 32'h2000, 32'h0);
    cycles = 0;
    for (int i = 0; i < 40; i++) begin
      if (!o_bus_req) break;
      cycles++;
      @(negedge i_clk);
    end
    tests_run++;
    if (cycles !== 16) begin
      tests_failed++;
      $display("FAIL timeout_len got=%0d want=16", cycles);
    end
    tests_run++;
    if ({o_rsp_valid, o_rsp_err, o_ld_data} !== {1'b1, 2'b11, 32'h0}) begin
      tests_failed++;
      $display("FAIL timeout_rsp got v=%b err=%b ld=%h want v=1 err=11 ld=0",
               o_rsp_valid, o_rsp_err, o_ld_data);
    end
    handshake();
    issue(3'b010, 1'b0, 32'h2000, 32'h0);
    repeat (15) @(negedge i_clk);
    ack_now(32'h0BADF00D);
    tests_run++;
    if ({o_rsp_valid, o_rsp_err, o_ld_data} !== {1'b1, 2'b00, 32'h0BADF00D}) begin
      tests_failed++;
      $display("FAIL timeout_last_ack got v=%b err=%b ld=%h want v=1 err=00 ld=0badf00d",
               o_rsp_valid, o_rsp_err, o_ld_data);
    end
    handshake();
  endtask

  task automatic test_backpressure();
    issue(3'b000, 1'b0, 32'h2001, 32'h0);
    ack_now(32'h80F01234);
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if ({o_rsp_valid, o_req_ready, o_rsp_err, o_ld_data} !== {2'b10, 2'b00, 32'h00000012}) begin
        tests_failed++;
        $display("FAIL stall[%0d] got v=%b rdy=%b err=%b ld=%h want v=1 rdy=0 err=00 ld=00000012",
                 i, o_rsp_valid, o_req_ready, o_rsp_err, o_ld_data);
      end
      @(negedge i_clk);
    end
    i_rsp_ready = 1'b1; i_req_valid = 1'b1; i_lsu_op = 3'b010; i_lsu_wren = 1'b0;
    i_lsu_addr = 32'h2008;
    @(posedge i_clk); @(negedge i_clk);
    i_rsp_ready = 1'b0;
    tests_run++;
    if ({o_req_ready, o_rsp_valid, o_bus_req} !== 3'b100) begin
      tests_failed++;
      $display("FAIL b2b_gap got rdy=%b v=%b req=%b want rdy=1 v=0 req=0",
               o_req_ready, o_rsp_valid, o_bus_req);
    end
    @(posedge i_clk); @(negedge i_clk);
    i_req_valid = 1'b0;
    tests_run++;
    if ({o_bus_req, o_bus_addr} !== {1'b1, 16'h2008}) begin
      tests_failed++;
      $display("FAIL b2b_accept got req=%b a=%h want req=1 a=2008", o_bus_req, o_bus_addr);
    end
    ack_now(32'h12345678);
    tests_run++;
    if (o_ld_data !== 32'h12345678) begin
      tests_failed++;
      $display("FAIL b2b_data got=%h want=12345678", o_ld_data);
    end
    handshake();
  endtask

  task automatic test_reset_mid();
    i_bus_ack = 1'b1; i_bus_rdata = 32'hFFFFFFFF;
    @(posedge i_clk); @(negedge i_clk);
    i_bus_ack = 1'b0;
    tests_run++;
    if ({o_req_ready, o_rsp_valid, o_bus_req} !== 3'b100) begin
      tests_failed++;
      $display("FAIL stray_ack got rdy=%b v=%b req=%b want 100", o_req_ready, o_rsp_valid, o_bus_req);
    end
    issue(3'b010, 1'b1, 32'h2000, 32'hCAFEBABE);
    tests_run++;
    if (o_bus_req !== 1'b1) begin
      tests_failed++;
      $display("FAIL midrst_bus got req=%b want 1", o_bus_req);
    end
    #2 i_rst = 1'b0;
    #1;
    tests_run++;
    if ({o_req_ready, o_rsp_valid, o_bus_req, o_bus_we, o_bus_be, o_bus_sel, o_bus_wdata} !==
        {4'b1000, 4'h0, 3'b000, 32'h0}) begin
      tests_failed++;
      $display("FAIL midrst_async got rdy=%b v=%b req=%b we=%b be=%b sel=%b wd=%h want rdy=1 rest=0",
               o_req_ready, o_rsp_valid, o_bus_req, o_bus_we, o_bus_be, o_bus_sel, o_bus_wdata);
    end
    @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    issue(3'b010, 1'b0, 32'h2004, 32'h0);
    ack_now(32'hCAFEF00D);
    tests_run++;
    if ({o_rsp_valid, o_rsp_err, o_ld_data} !== {1'b1, 2'b00, 32'hCAFEF00D}) begin
      tests_failed++;
      $display("FAIL midrst_next got v=%b err=%b ld=%h want v=1 err=00 ld=cafef00d",
               o_rsp_valid, o_rsp_err, o_ld_data);
    end
    handshake();
  endtask

  initial begin
    test_reset();
    test_store();
    test_loads();
    test_decode();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
